// File: rtl/bram_port_arbiter_pkg.sv
// Shared defaults and helpers for the BRAM port arbiter and its round-robin
// arbitration core.
package bram_port_arbiter_pkg;

  localparam int DEF_NUM_REQ         = 2;
  localparam int DEF_DATA_WIDTH      = 64;
  localparam int DEF_BRAM_ADDR_WIDTH = 16;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side request/response bundle of the BRAM port arbiter; requester
// i occupies slice i of every vector.
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*STRB_WIDTH-1:0]      req_we;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wrdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_addr, req_we, req_wrdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wrdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot single-grant arbiter: round-robin from a rotating pointer, or fixed
// priority (index 0 highest) when ROUND_ROBIN is 0.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int N           = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          found;

  // NOTE: every always_comb output gets a default before the loop, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    int            idx_i;
    logic [PW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx_i = (ROUND_ROBIN != 0) ? int'(ptr) + k : k;
      if (idx_i >= N) idx_i = idx_i - N;
      idx = PW'(idx_i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ROUND_ROBIN != 0 && found) begin
      ptr <= PW'(wrap_inc(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between NUM_REQ
// requesters, with a per-requester read buffer so response stalls stay local.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  bram_port_arbiter_if.slave         bus,
  output logic                       bram_en,
  output logic [DATA_WIDTH/8-1:0]    bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  input  logic [DATA_WIDTH-1:0]      bram_rddata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [NUM_REQ-1:0]    latched_q;
  logic [DATA_WIDTH-1:0] rsp_buf [NUM_REQ];

  // A requester may only be granted if its response slot is free next cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (!rsp_valid_q[i] || bus.rsp_ready[i]);
    end
  end

  rr_arbiter #(
    .N           (NUM_REQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (eligible),
    .grant (grant)
  );

  assign gnt           = rst ? '0 : grant;
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;

  always_comb begin
    bram_en     = |gnt;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bram_we     = bus.req_we[i*STRB_WIDTH +: STRB_WIDTH];
        bram_addr   = bus.req_addr[i*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
        bram_wrdata = bus.req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A new grant outranks consumption, giving back-to-back responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      latched_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          rsp_valid_q[i] <= 1'b1;
          latched_q[i]   <= 1'b0;
        end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
          latched_q[i]   <= 1'b0;
        end else if (rsp_valid_q[i] && !latched_q[i]) begin
          latched_q[i]   <= 1'b1;
        end
      end
    end
  end

  // NOTE: the buffers are only read while latched_q is set, which reset
  // clears, so the data storage itself carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_q[i] && !bus.rsp_ready[i] && !latched_q[i]) begin
        rsp_buf[i] <= bram_rddata;
      end
    end
  end

  always_comb begin
    bus.rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = latched_q[i] ? rsp_buf[i] : bram_rddata;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed tables and sequences,
// then randomized traffic against a queue-level reference model.
module tb_bram_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 64;
  localparam int AW      = 16;
  localparam int SW      = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) bus_rr ();
  bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) bus_fp ();

  logic          bram_en_rr, bram_en_fp;
  logic [SW-1:0] bram_we_rr, bram_we_fp;
  logic [AW-1:0] bram_addr_rr, bram_addr_fp;
  logic [DW-1:0] bram_wrdata_rr, bram_wrdata_fp;
  logic [DW-1:0] bram_rddata_rr = '0;
  logic [DW-1:0] bram_rddata_fp = '0;

  bram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .ROUND_ROBIN(1)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_rr.slave),
    .bram_en     (bram_en_rr),
    .bram_we     (bram_we_rr),
    .bram_addr   (bram_addr_rr),
    .bram_wrdata (bram_wrdata_rr),
    .bram_rddata (bram_rddata_rr)
  );

  bram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .ROUND_ROBIN(0)
  ) u_fp (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_fp.slave),
    .bram_en     (bram_en_fp),
    .bram_we     (bram_we_fp),
    .bram_addr   (bram_addr_fp),
    .bram_wrdata (bram_wrdata_fp),
    .bram_rddata (bram_rddata_fp)
  );

  // The fixed-priority instance sees the same requester stimulus.
  assign bus_fp.req_valid  = bus_rr.req_valid;
  assign bus_fp.req_addr   = bus_rr.req_addr;
  assign bus_fp.req_we     = bus_rr.req_we;
  assign bus_fp.req_wrdata = bus_rr.req_wrdata;
  assign bus_fp.rsp_ready  = bus_rr.rsp_ready;

  // BRAM models: 256 words, one-cycle read latency, byte write enables.
  logic [DW-1:0] mem     [256] = '{default: '0};
  logic [DW-1:0] mem_fp  [256] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  always @(posedge clk) begin
    if (bram_en_rr) begin
      bram_rddata_rr <= mem[bram_addr_rr[7:0]];
      for (int b = 0; b < SW; b++)
        if (bram_we_rr[b]) mem[bram_addr_rr[7:0]][b*8 +: 8] <= bram_wrdata_rr[b*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (bram_en_fp) begin
      bram_rddata_fp <= mem_fp[bram_addr_fp[7:0]];
      for (int b = 0; b < SW; b++)
        if (bram_we_fp[b]) mem_fp[bram_addr_fp[7:0]][b*8 +: 8] <= bram_wrdata_fp[b*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [SW-1:0] we, input logic [DW-1:0] d);
    for (int b = 0; b < SW; b++)
      if (we[b]) ref_mem[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Apply one cycle of stimulus just after the falling edge, then let it settle.
  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] rr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [SW-1:0] we0, input logic [SW-1:0] we1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1);
    @(negedge clk);
    rst               = r;
    bus_rr.req_valid  = v;
    bus_rr.rsp_ready  = rr;
    bus_rr.req_addr   = {a1, a0};
    bus_rr.req_we     = {we1, we0};
    bus_rr.req_wrdata = {wd1, wd0};
    #1;
  endtask

  typedef struct {
    logic [1:0]    v;
    logic [1:0]    rr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    ready;
    logic [1:0]    fp_ready;
    logic [1:0]    rspv;
    logic          en;
    logic [AW-1:0] addr;
    logic [1:0]    chk_d;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } vec_t;

  vec_t tbl [6];

  // Reference model state for the random phase.
  logic          hv     [NUM_REQ];
  logic [AW-1:0] ha     [NUM_REQ];
  logic [SW-1:0] hwe    [NUM_REQ];
  logic [DW-1:0] hwd    [NUM_REQ];
  logic          rrv    [NUM_REQ];
  logic          pend   [NUM_REQ];
  logic          pend_rd[NUM_REQ];
  logic [DW-1:0] exp_d  [NUM_REQ];

  initial begin
    bus_rr.req_valid  = '0;
    bus_rr.rsp_ready  = '0;
    bus_rr.req_addr   = '0;
    bus_rr.req_we     = '0;
    bus_rr.req_wrdata = '0;

    // Reset with both requesters valid: nothing granted, no BRAM access.
    drive(1'b1, 2'b11, 2'b11, 16'h1, 16'h2, '0, '0, '0, '0);
    check("reset_rspv", bus_rr.rsp_valid, 2'b00);
    check("reset_ready", bus_rr.req_ready, 2'b00);
    check("reset_en", bram_en_rr, 1'b0);

    // Preload through the DUT.
    drive(1'b0, 2'b01, 2'b11, 16'h1, '0, 8'hFF, '0, 64'h1111, '0);
    check("setup_wr_en", bram_en_rr, 1'b1);
    ref_write(16'h1, 8'hFF, 64'h1111);
    drive(1'b0, 2'b01, 2'b11, 16'h2, '0, 8'hFF, '0, 64'h2222, '0);
    ref_write(16'h2, 8'hFF, 64'h2222);
    drive(1'b0, 2'b01, 2'b11, 16'h5, '0, 8'hFF, '0, 64'h55, '0);
    ref_write(16'h5, 8'hFF, 64'h55);
    // Reset while a write ack is pending.
    drive(1'b1, 2'b11, 2'b11, 16'h1, 16'h2, '0, '0, '0, '0);
    check("rst2_ready", bus_rr.req_ready, 2'b00);
    check("rst2_en", bram_en_rr, 1'b0);

    // Two requesters contending continuously.
    tbl[0] = '{2'b11, 2'b11, 16'h1, 16'h2, 2'b01, 2'b01, 2'b00, 1'b1, 16'h1, 2'b00, '0, '0};
    tbl[1] = '{2'b11, 2'b11, 16'h1, 16'h2, 2'b10, 2'b01, 2'b01, 1'b1, 16'h2, 2'b01, 64'h1111, '0};
    tbl[2] = '{2'b11, 2'b11, 16'h1, 16'h2, 2'b01, 2'b01, 2'b10, 1'b1, 16'h1, 2'b10, '0, 64'h2222};
    tbl[3] = '{2'b11, 2'b11, 16'h1, 16'h2, 2'b10, 2'b01, 2'b01, 1'b1, 16'h2, 2'b01, 64'h1111, '0};
    tbl[4] = '{2'b00, 2'b11, 16'h1, 16'h2, 2'b00, 2'b00, 2'b10, 1'b0, '0, 2'b10, '0, 64'h2222};
    tbl[5] = '{2'b00, 2'b11, 16'h1, 16'h2, 2'b00, 2'b00, 2'b00, 1'b0, '0, 2'b00, '0, '0};
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, tbl[t].v, tbl[t].rr, tbl[t].a0, tbl[t].a1, '0, '0, '0, '0);
      check($sformatf("tbl%0d_ready", t), bus_rr.req_ready, tbl[t].ready);
      check($sformatf("tbl%0d_fp_ready", t), bus_fp.req_ready, tbl[t].fp_ready);
      check($sformatf("tbl%0d_rspv", t), bus_rr.rsp_valid, tbl[t].rspv);
      check($sformatf("tbl%0d_en", t), bram_en_rr, tbl[t].en);
      if (tbl[t].en) check($sformatf("tbl%0d_addr", t), bram_addr_rr, tbl[t].addr);
      if (tbl[t].chk_d[0]) check($sformatf("tbl%0d_d0", t), bus_rr.rsp_data[DW-1:0], tbl[t].d0);
      if (tbl[t].chk_d[1]) check($sformatf("tbl%0d_d1", t), bus_rr.rsp_data[2*DW-1:DW], tbl[t].d1);
    end

    // Requester 1 stalls its response; requester 0 keeps flowing.
    drive(1'b0, 2'b10, 2'b01, '0, 16'h5, '0, '0, '0, '0);
    check("hold_a_ready", bus_rr.req_ready, 2'b10);
    drive(1'b0, 2'b01, 2'b01, 16'h1, 16'h5, '0, '0, '0, '0);
    check("hold_b_ready", bus_rr.req_ready, 2'b01);
    check("hold_b_rspv1", bus_rr.rsp_valid[1], 1'b1);
    check("hold_b_d1", bus_rr.rsp_data[2*DW-1:DW], 64'h55);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'b11, 2'b01, (c == 1) ? 16'h1 : 16'h2, 16'h5, '0, '0, '0, '0);
      check($sformatf("hold_c%0d_ready", c), bus_rr.req_ready, 2'b01);
      check($sformatf("hold_c%0d_rspv1", c), bus_rr.rsp_valid[1], 1'b1);
      check($sformatf("hold_c%0d_d1", c), bus_rr.rsp_data[2*DW-1:DW], 64'h55);
      check($sformatf("hold_c%0d_d0", c), bus_rr.rsp_data[DW-1:0], (c == 1) ? 64'h2222 : 64'h1111);
    end
    drive(1'b0, 2'b11, 2'b11, 16'h1, 16'h5, '0, '0, '0, '0);
    check("hold_f_ready", bus_rr.req_ready, 2'b10);
    check("hold_f_d1", bus_rr.rsp_data[2*DW-1:DW], 64'h55);
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("hold_g_rspv", bus_rr.rsp_valid, 2'b10);
    check("hold_g_d1", bus_rr.rsp_data[2*DW-1:DW], 64'h55);
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("hold_h_rspv", bus_rr.rsp_valid, 2'b00);

    // Full write then read-back on requester 0.
    drive(1'b0, 2'b01, 2'b11, 16'h10, '0, 8'hFF, '0, 64'hDEADBEEF_00000001, '0);
    check("wr_en", bram_en_rr, 1'b1);
    check("wr_we", bram_we_rr, 8'hFF);
    check("wr_addr", bram_addr_rr, 16'h10);
    ref_write(16'h10, 8'hFF, 64'hDEADBEEF_00000001);
    drive(1'b0, 2'b01, 2'b11, 16'h10, '0, '0, '0, '0, '0);
    check("rd_en", bram_en_rr, 1'b1);
    check("rd_we", bram_we_rr, 8'h00);
    check("wr_ack", bus_rr.rsp_valid[0], 1'b1);
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("rd_rspv", bus_rr.rsp_valid[0], 1'b1);
    check("rd_data", bus_rr.rsp_data[DW-1:0], 64'hDEADBEEF_00000001);

    // Partial write over word 0.
    drive(1'b0, 2'b01, 2'b11, 16'h0, '0, 8'h0F, '0, 64'hFFFFFFFF_FFFFFFFF, '0);
    ref_write(16'h0, 8'h0F, 64'hFFFFFFFF_FFFFFFFF);
    drive(1'b0, 2'b01, 2'b11, 16'h0, '0, '0, '0, '0, '0);
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("pwr_data", bus_rr.rsp_data[DW-1:0], 64'h00000000_FFFFFFFF);

    // Back-to-back reads 0..7.
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, (k < 8) ? 2'b01 : 2'b00, 2'b11, AW'(k), '0, '0, '0, '0, '0);
      if (k < 8) check($sformatf("b2b%0d_ready", k), bus_rr.req_ready, 2'b01);
      if (k > 0) begin
        check($sformatf("b2b%0d_rspv", k), bus_rr.rsp_valid[0], 1'b1);
        check($sformatf("b2b%0d_data", k), bus_rr.rsp_data[DW-1:0], ref_mem[k-1]);
      end
    end
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("b2b_end_rspv", bus_rr.rsp_valid, 2'b00);

    // Reset in the response-pending cycle, with a write that must be dropped.
    drive(1'b0, 2'b01, 2'b00, 16'h3, '0, '0, '0, '0, '0);
    check("rstm_grant", bus_rr.req_ready, 2'b01);
    drive(1'b1, 2'b01, 2'b00, 16'h20, '0, 8'hFF, '0, 64'hBAD, '0);
    check("rstm_ready", bus_rr.req_ready, 2'b00);
    check("rstm_en", bram_en_rr, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 16'h20, 16'h2, '0, '0, '0, '0);
    check("rstm_rspv", bus_rr.rsp_valid, 2'b00);
    check("rstm_ptr", bus_rr.req_ready, 2'b01);
    drive(1'b0, 2'b00, 2'b11, '0, '0, '0, '0, '0, '0);
    check("rstm_rspv0", bus_rr.rsp_valid, 2'b01);
    check("rstm_nowrite", bus_rr.rsp_data[DW-1:0], ref_mem[8'h20]);

    // Randomized traffic against the reference model.
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    begin
      int p_m;
      p_m = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hv[i] = 1'b0; pend[i] = 1'b0; pend_rd[i] = 1'b0; exp_d[i] = '0;
        ha[i] = '0; hwe[i] = '0; hwd[i] = '0; rrv[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
        int g;
        logic [1:0] exp_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!hv[i] && $urandom_range(0, 3) != 0) begin
            hv[i]  = 1'b1;
            ha[i]  = AW'($urandom_range(0, 15));
            hwe[i] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
            hwd[i] = {$urandom, $urandom};
          end
          rrv[i] = ($urandom_range(0, 3) != 0);
        end
        drive(1'b0, {hv[1], hv[0]}, {rrv[1], rrv[0]}, ha[0], ha[1], hwe[0], hwe[1], hwd[0], hwd[1]);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (p_m + k) % NUM_REQ;
          if (g < 0 && hv[idx] && (!pend[idx] || rrv[idx])) g = idx;
        end
        exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
        check("rand_ready", bus_rr.req_ready, exp_ready);
        check("rand_en", bram_en_rr, g >= 0);
        if (g >= 0) begin
          check("rand_addr", bram_addr_rr, ha[g]);
          check("rand_we", bram_we_rr, hwe[g]);
          if (hwe[g] != '0) check("rand_wrdata", bram_wrdata_rr, hwd[g]);
        end
        check("rand_rspv", bus_rr.rsp_valid, {pend[1], pend[0]});
        for (int i = 0; i < NUM_REQ; i++)
          if (pend[i] && pend_rd[i]) check($sformatf("rand_data%0d", i), bus_rr.rsp_data[i*DW +: DW], exp_d[i]);
        for (int i = 0; i < NUM_REQ; i++)
          if (pend[i] && rrv[i]) pend[i] = 1'b0;
        if (g >= 0) begin
          pend[g]    = 1'b1;
          pend_rd[g] = (hwe[g] == '0);
          exp_d[g]   = ref_mem[ha[g][7:0]];
          ref_write(ha[g], hwe[g], hwd[g]);
          hv[g]      = 1'b0;
          p_m        = (g + 1) % NUM_REQ;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Shares one single-port BRAM (1-cycle read latency, byte write enables) between NUM_REQ requesters.
Each requester has a valid/ready request port and a valid/ready response port, so AXI-lite-to-BRAM controllers, DMA engines and debug ports can coexist on one memory.
Arbitration is one grant per cycle, round-robin or fixed priority. Read data is buffered per requester, so response back-pressure never stalls other requesters.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
DATA_WIDTH, 64, BRAM data width; multiple of 8
BRAM_ADDR_WIDTH, 16, BRAM word address width
ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority (index 0 highest)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted (grant) per requester
req_addr  in  NUM_REQ*BRAM_ADDR_WIDTH  word address, requester i at slice i
req_we  in  NUM_REQ*DATA_WIDTH/8  byte write strobes; all-zero = read
req_wrdata  in  NUM_REQ*DATA_WIDTH  write data
rsp_valid  out  NUM_REQ  response valid
rsp_ready  in  NUM_REQ  response consumed
rsp_data  out  NUM_REQ*DATA_WIDTH  read data (undefined for write responses)
bram_en  out  1  BRAM enable
bram_we  out  DATA_WIDTH/8  BRAM byte write enable
bram_addr  out  BRAM_ADDR_WIDTH  BRAM address
bram_wrdata  out  DATA_WIDTH  BRAM write data
bram_rddata  in  DATA_WIDTH  BRAM read data, valid the cycle after bram_en

Behaviour:
- Eligibility: requester i is eligible iff req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A requester's response slot must be free next cycle.
- Grant: at most one eligible requester per cycle. req_ready is one-hot or zero, combinational from req_valid/rsp_valid/rsp_ready.
  - req_ready[i] never asserts without req_valid[i].
  - Requesters must not make valid depend on ready.
- Round-robin: pointer register p, reset 0. The search starts at p, wrapping NUM_REQ-1 -> 0. After a grant to g, p <= (g+1) mod NUM_REQ. With no grant, p holds. Fixed priority: lowest eligible index wins; p is unused.
- BRAM drive on grant g: bram_en=1, bram_addr=req_addr[g], bram_we=req_we[g], bram_wrdata=req_wrdata[g].
- With no grant: bram_en=0, bram_we=0; addr/wrdata are don't-care (drive slice of p or 0).
- Response timing: a grant in cycle T sets rsp_valid[g]=1 in T+1. Writes also produce a response (ack). Minimum request-to-response latency is 1 cycle.
- Response data:
  - In the first response cycle, rsp_data[i] = bram_rddata (fall-through).
  - If rsp_valid[i] && !rsp_ready[i] in that first cycle, latch bram_rddata into a per-requester buffer, set latched[i].
  - While latched[i]=1, rsp_data[i] = buffer.
- rsp_valid[i] clears on rsp_valid[i] && rsp_ready[i], unless a new grant to i occurs in the same cycle; that grant wins, giving back-to-back responses. latched[i] clears on consumption.
- Throughput: one request per cycle total. A single requester with rsp_ready held high is granted every cycle.
- Simultaneous events: two requesters eligible -> only the pointer-nearest is granted; the other sees req_ready=0 and must hold its request stable.
- Reset (any cycle, including mid-transfer): rsp_valid=0, latched=0, p=0, buffers don't-care. In-flight responses are dropped and req_ready=0 in the reset cycle. The BRAM write of a grant coinciding with reset is suppressed (bram_en=0 while rst).

Decomposition:
- No shared package types; widths are localparams (STRB_WIDTH=DATA_WIDTH/8).
- Sub-module rr_arbiter: parameters N, ROUND_ROBIN; ports clk, rst, req[N], grant[N] (one-hot, combinational), with the pointer register inside.
- Reusable for other shared-resource blocks.

Test Plan:
- Single requester 0: write addr 0x10 data 0xDEADBEEF_00000001, we=0xFF, then read 0x10 -> bram_en both cycles, rsp_valid[0] at T+1 each, read rsp_data=0xDEADBEEF_00000001.
- Both requesters continuously valid reading 0x1/0x2, rsp_ready=1 -> grants alternate 0,1,0,1; each gets 1 response per 2 cycles; ROUND_ROBIN=0 -> requester 0 granted every cycle, requester 1 starved.
- Requester 1 reads 0x5 (mem=0x55), rsp_ready[1]=0 for 4 cycles -> rsp_data[1] stays 0x55 after bram_rddata changes; req 1 not granted again; requester 0 still granted each cycle.
- Back-to-back: requester 0 reads 0x0..0x7 with rsp_ready=1 -> 8 consecutive responses, rsp_valid[0] never drops between them, data in order.
- Partial write we=0x0F data 0xFFFFFFFF_FFFFFFFF over 0x0 -> readback 0x00000000_FFFFFFFF.
- Assert rst in the response-pending cycle -> next cycle rsp_valid=0, p=0, no bram_en during rst.
